// File: rtl/ab_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// ab_write_arbiter_if
//
// Bundles the ALU writeback, host write channel and A/B memory write port
// seen by ab_write_arbiter.
//   slave  : the arbiter (consumes ALU/host requests, drives the write port)
//   master : the surrounding logic / testbench
//
// Signals:
//   alu_wb_valid, alu_op, alu_D, alu_result   ALU writeback request
//   host_valid, host_ready, host_sel_b,
//   host_addr, host_data                      host write channel
//   A_write_addr, B_write_addr, mem_write_data,
//   mem_write_op, A_wren_other, B_wren_other  registered memory write port
//   fifo_count, host_starved                  host FIFO status
// ---------------------------------------------------------------------------
interface ab_write_arbiter_if #(
    parameter int unsigned WORD_WIDTH   = 36,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH   = 4
);
    logic                          alu_wb_valid;
    logic [OPCODE_WIDTH-1:0]       alu_op;
    logic [ADDR_WIDTH:0]           alu_D;
    logic [WORD_WIDTH-1:0]         alu_result;

    logic                          host_valid;
    logic                          host_ready;
    logic                          host_sel_b;
    logic [ADDR_WIDTH-1:0]         host_addr;
    logic [WORD_WIDTH-1:0]         host_data;

    logic [ADDR_WIDTH-1:0]         A_write_addr;
    logic [ADDR_WIDTH-1:0]         B_write_addr;
    logic [WORD_WIDTH-1:0]         mem_write_data;
    logic [OPCODE_WIDTH-1:0]       mem_write_op;
    logic                          A_wren_other;
    logic                          B_wren_other;

    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          host_starved;

    modport slave (
        input  alu_wb_valid, alu_op, alu_D, alu_result,
        input  host_valid, host_sel_b, host_addr, host_data,
        output host_ready,
        output A_write_addr, B_write_addr, mem_write_data, mem_write_op,
        output A_wren_other, B_wren_other,
        output fifo_count, host_starved
    );

    modport master (
        output alu_wb_valid, alu_op, alu_D, alu_result,
        output host_valid, host_sel_b, host_addr, host_data,
        input  host_ready,
        input  A_write_addr, B_write_addr, mem_write_data, mem_write_op,
        input  A_wren_other, B_wren_other,
        input  fifo_count, host_starved
    );
endinterface

// File: rtl/ab_write_arbiter.sv
// ---------------------------------------------------------------------------
// ab_write_arbiter
//
// Shares the datapath A/B memory write port between ALU writeback and a host
// write channel. ALU writeback always wins; host writes are buffered in a
// FIFO and drained into cycles with no ALU writeback. All write-port outputs
// are registered.
//
// Ports:
//   clock     sole clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       ab_write_arbiter_if.slave (ALU request, host channel,
//             memory write port, FIFO status)
//
// Optional feature macro AB_WRITE_ARBITER_STATS_EN adds:
//   stat_host_writes     32-bit wrapping count of host FIFO pops
//   stat_blocked_cycles  32-bit wrapping count of cycles with the FIFO
//                        non-empty while an ALU writeback holds the port
// ---------------------------------------------------------------------------
module ab_write_arbiter #(
    parameter int unsigned WORD_WIDTH   = 36,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned HOST_OP      = 0,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ab_write_arbiter_if.slave     bus
`ifdef AB_WRITE_ARBITER_STATS_EN
    ,
    output logic [31:0]           stat_host_writes,
    output logic [31:0]           stat_blocked_cycles
`endif
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic                  sel_b;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    entry_t                  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    ready_en;
    logic [STARVE_W-1:0]     starve_cnt;

    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    host_ready_i;
    entry_t                  head;
    entry_t                  push_entry;

    logic [ADDR_WIDTH-1:0]   a_addr_q;
    logic [ADDR_WIDTH-1:0]   b_addr_q;
    logic [WORD_WIDTH-1:0]   data_q;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic                    a_wren_q;
    logic                    b_wren_q;

    // ready_en keeps host_ready low while reset is held and through the
    // release edge, so acceptance starts only on a clean post-reset cycle.
    assign fifo_empty   = (count == '0);
    assign host_ready_i = ready_en && (count != CNT_W'(FIFO_DEPTH));
    assign push         = bus.host_valid && host_ready_i;
    // Pop is decided from the registered count, so an entry pushed this
    // cycle can never be forwarded in the same cycle.
    assign pop          = !bus.alu_wb_valid && !fifo_empty;
    assign head         = fifo_mem[rd_ptr];

    always_comb begin
        push_entry       = '0;
        push_entry.sel_b = bus.host_sel_b;
        push_entry.addr  = bus.host_addr;
        push_entry.data  = bus.host_data;
    end

    // Storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Write port. Host writes put their address on both address outputs,
    // mirroring the ALU path; only the selected wren qualifies it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_addr_q <= '0;
            b_addr_q <= '0;
            data_q   <= '0;
            op_q     <= '0;
            a_wren_q <= 1'b0;
            b_wren_q <= 1'b0;
        end else if (bus.alu_wb_valid) begin
            a_addr_q <= bus.alu_D[ADDR_WIDTH-1:0];
            b_addr_q <= bus.alu_D[ADDR_WIDTH-1:0];
            data_q   <= bus.alu_result;
            op_q     <= bus.alu_op;
            a_wren_q <= !bus.alu_D[ADDR_WIDTH];
            b_wren_q <= bus.alu_D[ADDR_WIDTH];
        end else if (pop) begin
            a_addr_q <= head.addr;
            b_addr_q <= head.addr;
            data_q   <= head.data;
            op_q     <= OPCODE_WIDTH'(HOST_OP);
            a_wren_q <= !head.sel_b;
            b_wren_q <= head.sel_b;
        end else begin
            a_wren_q <= 1'b0;
            b_wren_q <= 1'b0;
        end
    end

    // Saturating count of consecutive cycles the head is held off by ALU
    // writeback; any other cycle is either a pop or an empty FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (bus.alu_wb_valid && !fifo_empty) begin
            if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

`ifdef AB_WRITE_ARBITER_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_host_writes    <= '0;
            stat_blocked_cycles <= '0;
        end else begin
            if (pop) begin
                stat_host_writes <= stat_host_writes + 32'd1;
            end
            if (bus.alu_wb_valid && !fifo_empty) begin
                stat_blocked_cycles <= stat_blocked_cycles + 32'd1;
            end
        end
    end
`endif

    assign bus.host_ready     = host_ready_i;
    assign bus.A_write_addr   = a_addr_q;
    assign bus.B_write_addr   = b_addr_q;
    assign bus.mem_write_data = data_q;
    assign bus.mem_write_op   = op_q;
    assign bus.A_wren_other   = a_wren_q;
    assign bus.B_wren_other   = b_wren_q;
    assign bus.fifo_count     = count;
    assign bus.host_starved   = (starve_cnt == STARVE_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_ab_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ab_write_arbiter
//
// Randomized and directed stimulus for ab_write_arbiter, checked every
// falling edge against a queue-based reference model of the arbitration
// rules, plus literal expectations for the directed scenarios.
// Optional macro AB_WRITE_ARBITER_STATS_EN enables the statistics checks.
// ---------------------------------------------------------------------------
module tb_ab_write_arbiter;

    localparam int unsigned WW    = 36;
    localparam int unsigned AW    = 10;
    localparam int unsigned OW    = 4;
    localparam int unsigned HOP   = 0;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 64;

    logic clock;
    logic reset_n;

    ab_write_arbiter_if #(
        .WORD_WIDTH  (WW),
        .ADDR_WIDTH  (AW),
        .OPCODE_WIDTH(OW),
        .FIFO_DEPTH  (DEPTH)
    ) bus ();

`ifdef AB_WRITE_ARBITER_STATS_EN
    logic [31:0] stat_host_writes;
    logic [31:0] stat_blocked_cycles;
`endif

    ab_write_arbiter #(
        .WORD_WIDTH  (WW),
        .ADDR_WIDTH  (AW),
        .OPCODE_WIDTH(OW),
        .HOST_OP     (HOP),
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef AB_WRITE_ARBITER_STATS_EN
        ,
        .stat_host_writes   (stat_host_writes),
        .stat_blocked_cycles(stat_blocked_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: host FIFO as a queue, write port as last-issued
    // values, starvation as a plain saturating integer.
    // ------------------------------------------------------------------
    typedef struct {
        bit          sel_b;
        bit [AW-1:0] addr;
        bit [WW-1:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_a_wren, m_b_wren, m_ready_en;
    bit [AW-1:0] m_a_addr, m_b_addr;
    bit [WW-1:0] m_data;
    bit [OW-1:0] m_op;
    int          m_starve;
    int          m_pops, m_blocked;

    always @(posedge clock or negedge reset_n) begin
        bit   acc;
        int   sz;
        ent_t e;
        if (!reset_n) begin
            q.delete();
            m_a_wren = 0; m_b_wren = 0; m_ready_en = 0;
            m_a_addr = '0; m_b_addr = '0; m_data = '0; m_op = '0;
            m_starve = 0; m_pops = 0; m_blocked = 0;
        end else begin
            sz  = q.size();
            acc = bus.host_valid && m_ready_en && (sz != DEPTH);
            if (bus.alu_wb_valid) begin
                m_a_addr = bus.alu_D[AW-1:0];
                m_b_addr = bus.alu_D[AW-1:0];
                m_data   = bus.alu_result;
                m_op     = bus.alu_op;
                m_a_wren = !bus.alu_D[AW];
                m_b_wren = bus.alu_D[AW];
                if (sz > 0) begin
                    m_blocked++;
                    m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
                end else begin
                    m_starve = 0;
                end
            end else if (sz > 0) begin
                e = q.pop_front();
                m_a_addr = e.addr;
                m_b_addr = e.addr;
                m_data   = e.data;
                m_op     = OW'(HOP);
                m_a_wren = !e.sel_b;
                m_b_wren = e.sel_b;
                m_starve = 0;
                m_pops++;
            end else begin
                m_a_wren = 0;
                m_b_wren = 0;
                m_starve = 0;
            end
            if (acc) begin
                e.sel_b = bus.host_sel_b;
                e.addr  = bus.host_addr;
                e.data  = bus.host_data;
                q.push_back(e);
            end
            m_ready_en = 1;
        end
    end

    always @(negedge clock) begin
        chk("A_wren",  64'(bus.A_wren_other),   64'(m_a_wren));
        chk("B_wren",  64'(bus.B_wren_other),   64'(m_b_wren));
        chk("A_addr",  64'(bus.A_write_addr),   64'(m_a_addr));
        chk("B_addr",  64'(bus.B_write_addr),   64'(m_b_addr));
        chk("data",    64'(bus.mem_write_data), 64'(m_data));
        chk("op",      64'(bus.mem_write_op),   64'(m_op));
        chk("count",   64'(bus.fifo_count),     64'(q.size()));
        chk("ready",   64'(bus.host_ready),     64'(m_ready_en && (q.size() != DEPTH)));
        chk("starved", 64'(bus.host_starved),   64'(m_starve == LIMIT));
        chk("one_wren", 64'(bus.A_wren_other && bus.B_wren_other), 64'(0));
`ifdef AB_WRITE_ARBITER_STATS_EN
        chk("stat_hw",  64'(stat_host_writes),    64'(m_pops));
        chk("stat_blk", 64'(stat_blocked_cycles), 64'(m_blocked));
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_alu();
        bus.alu_op     = OW'($urandom);
        bus.alu_result = {4'($urandom), 32'($urandom)};
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_op       = '0;
        bus.alu_D        = '0;
        bus.alu_result   = '0;
        bus.host_valid   = 1'b0;
        bus.host_sel_b   = 1'b0;
        bus.host_addr    = '0;
        bus.host_data    = '0;

        // Reset state and release behaviour
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready",  64'(bus.host_ready), 64'(0));
        chk("rst_count",  64'(bus.fifo_count), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rel_ready0", 64'(bus.host_ready), 64'(0));
        cyc();
        chk("rel_ready1", 64'(bus.host_ready), 64'(1));

        // Single host write, idle ALU: wren two cycles after accept
        bus.host_valid = 1'b1;
        bus.host_sel_b = 1'b0;
        bus.host_addr  = 10'h005;
        bus.host_data  = 36'h123;
        cyc();
        bus.host_valid = 1'b0;
        chk("h1_wren_n1", 64'(bus.A_wren_other), 64'(0));
        chk("h1_cnt_n1",  64'(bus.fifo_count),   64'(1));
        cyc();
        chk("h1_wren",    64'(bus.A_wren_other),   64'(1));
        chk("h1_bwren",   64'(bus.B_wren_other),   64'(0));
        chk("h1_addr",    64'(bus.A_write_addr),   64'(10'h005));
        chk("h1_data",    64'(bus.mem_write_data), 64'(36'h123));
        chk("h1_op",      64'(bus.mem_write_op),   64'(HOP));
        cyc();
        chk("h1_wren_off", 64'(bus.A_wren_other), 64'(0));

        // Continuous ALU writeback to B: fill, starve, then drain in order
        bus.alu_wb_valid = 1'b1;
        bus.alu_D        = 11'h410;
        for (int unsigned i = 0; i < 4; i++) begin
            rand_alu();
            bus.host_valid = 1'b1;
            bus.host_sel_b = i[0];
            bus.host_addr  = AW'(10'h020 + i);
            bus.host_data  = WW'(36'hA0 + i);
            cyc();
        end
        bus.host_valid = 1'b0;
        chk("full_ready", 64'(bus.host_ready),   64'(0));
        chk("full_count", 64'(bus.fifo_count),   64'(4));
        chk("alu_bwren",  64'(bus.B_wren_other), 64'(1));
        chk("alu_awren",  64'(bus.A_wren_other), 64'(0));
        chk("alu_baddr",  64'(bus.B_write_addr), 64'(10'h010));
        repeat (70) begin
            rand_alu();
            cyc();
        end
        chk("starved_on", 64'(bus.host_starved), 64'(1));
        chk("starve_cnt", 64'(bus.fifo_count),   64'(4));
        bus.alu_wb_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cyc();
            chk("drain_data",  64'(bus.mem_write_data), 64'(36'hA0 + i));
            chk("drain_awren", 64'(bus.A_wren_other),   64'(!i[0]));
            chk("drain_bwren", 64'(bus.B_wren_other),   64'(i[0]));
            chk("drain_addr",  64'(i[0] ? bus.B_write_addr : bus.A_write_addr), 64'(10'h020 + i));
            chk("drain_op",    64'(bus.mem_write_op),   64'(HOP));
            chk("drain_starv", 64'(bus.host_starved),   64'(0));
        end
        cyc();
        chk("drain_empty", 64'(bus.fifo_count), 64'(0));

        // Simultaneous push and pop at count=2
        bus.alu_wb_valid = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            rand_alu();
            bus.host_valid = 1'b1;
            bus.host_data  = WW'(36'hB0 + i);
            cyc();
        end
        chk("pp_cnt_pre", 64'(bus.fifo_count), 64'(2));
        bus.alu_wb_valid = 1'b0;
        bus.host_data    = 36'hB2;
        cyc();
        bus.host_valid = 1'b0;
        chk("pp_cnt",  64'(bus.fifo_count),     64'(2));
        chk("pp_data", 64'(bus.mem_write_data), 64'(36'hB0));
        repeat (3) cyc();

        // Alternating ALU valid/idle with random host stream
        for (int unsigned i = 0; i < 300; i++) begin
            bus.alu_wb_valid = i[0];
            bus.alu_D        = AW'($urandom) | (11'($urandom_range(0, 1)) << AW);
            rand_alu();
            bus.host_valid   = 1'($urandom_range(0, 1));
            bus.host_sel_b   = 1'($urandom);
            bus.host_addr    = AW'($urandom);
            bus.host_data    = {4'($urandom), 32'($urandom)};
            cyc();
        end
        // Heavier ALU load
        for (int unsigned i = 0; i < 300; i++) begin
            bus.alu_wb_valid = ($urandom_range(0, 3) != 0);
            bus.alu_D        = 11'($urandom);
            rand_alu();
            bus.host_valid   = 1'($urandom_range(0, 1));
            bus.host_sel_b   = 1'($urandom);
            bus.host_addr    = AW'($urandom);
            bus.host_data    = {4'($urandom), 32'($urandom)};
            cyc();
        end
        bus.alu_wb_valid = 1'b0;
        bus.host_valid   = 1'b0;
        repeat (8) cyc();
        chk("rand_empty", 64'(bus.fifo_count), 64'(0));

        // Reset asserted mid-drain with count=3
        bus.alu_wb_valid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            rand_alu();
            bus.host_valid = 1'b1;
            bus.host_sel_b = 1'b1;
            bus.host_addr  = AW'(10'h100 + i);
            bus.host_data  = WW'(36'hC0 + i);
            cyc();
        end
        bus.alu_wb_valid = 1'b0;
        cyc();
        cyc();
        chk("md_count", 64'(bus.fifo_count),   64'(3));
        chk("md_bwren", 64'(bus.B_wren_other), 64'(1));
        #3;
        reset_n        = 1'b0;
        bus.host_valid = 1'b0;
        #1;
        chk("mr_awren", 64'(bus.A_wren_other),   64'(0));
        chk("mr_bwren", 64'(bus.B_wren_other),   64'(0));
        chk("mr_aaddr", 64'(bus.A_write_addr),   64'(0));
        chk("mr_baddr", 64'(bus.B_write_addr),   64'(0));
        chk("mr_data",  64'(bus.mem_write_data), 64'(0));
        chk("mr_op",    64'(bus.mem_write_op),   64'(0));
        chk("mr_count", 64'(bus.fifo_count),     64'(0));
        chk("mr_ready", 64'(bus.host_ready),     64'(0));
        repeat (2) cyc();
        chk("mr_ready_hold", 64'(bus.host_ready), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("mr_rel_ready0", 64'(bus.host_ready), 64'(0));
        cyc();
        chk("mr_rel_ready1", 64'(bus.host_ready), 64'(1));
        chk("mr_rel_count",  64'(bus.fifo_count), 64'(0));

        // Five host writes with exactly seven blocked cycles
        for (int unsigned i = 0; i < 4; i++) begin
            bus.host_valid = 1'b1;
            bus.host_sel_b = 1'b0;
            bus.host_addr  = AW'(10'h200 + i);
            bus.host_data  = WW'(36'hD0 + i);
            cyc();
        end
        bus.host_valid = 1'b0;
        repeat (2) cyc();
        bus.alu_wb_valid = 1'b1;
        bus.host_valid   = 1'b1;
        bus.host_data    = 36'hD4;
        rand_alu();
        cyc();
        bus.host_valid = 1'b0;
        repeat (7) begin
            rand_alu();
            cyc();
        end
        chk("st_count",   64'(bus.fifo_count),   64'(1));
        chk("st_starved", 64'(bus.host_starved), 64'(0));
        bus.alu_wb_valid = 1'b0;
        cyc();
        chk("st_pop_data", 64'(bus.mem_write_data), 64'(36'hD4));
        cyc();
`ifdef AB_WRITE_ARBITER_STATS_EN
        chk("stat_hw_5",  64'(stat_host_writes),    64'(5));
        chk("stat_blk_7", 64'(stat_blocked_cycles), 64'(7));
`endif

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
